mult4u_result_checker: RTL and testbench
========================================

Name: mult4u_result_checker

Overview:
- Downstream checking stage for the combinational 4-bit unsigned multipliers.
- Accepts one transaction per handshake: operands A, B and the product the multiplier produced for them.
- Recomputes a golden product with a sequential shift-add datapath and flags any mismatch.
- Keeps a saturating error count, used to measure observed fault escapes during fault-injection campaigns.

Parameters:
- W, 4: operand width; product width is 2*W.
- CNT_W, 16: width of the error counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream transaction valid.
- in_ready  output  1  checker can accept a transaction.
- in_a  input  W  operand A (A[3:0] of the multiplier).
- in_b  input  W  operand B (B[3:0] of the multiplier).
- in_prod  input  2*W  product under test (O[7:0] of the multiplier).
- out_valid  output  1  check result valid.
- out_ready  input  1  downstream accepts the result.
- out_prod  output  2*W  captured product under test.
- out_golden  output  2*W  reference product A*B.
- out_err  output  1  1 when out_prod != out_golden.
- clr_count  input  1  synchronous clear of err_count and err_sat.
- err_count  output  CNT_W  number of mismatches handed downstream.
- err_sat  output  1  sticky flag: err_count has reached all-ones.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - in_ready=0, out_valid=0, out_err=0.
  - out_prod, out_golden, err_count and err_sat all go to 0.
  - Any in-flight transaction is discarded; no partial result is ever presented.
- in_ready is registered. It rises on the first clk edge after rst_n deasserts and is 1 only in IDLE.
- States are IDLE, MUL and REPORT.
- IDLE:
  - The input handshake fires when in_valid and in_ready are both high at a clk edge.
  - On that edge: capture in_a, in_b and in_prod; clear the accumulator; set step=0; in_ready drops; go to MUL.
- MUL:
  - Each edge: if b_q[step]=1 then acc = acc + (a_q << step), as a 2*W-bit add that never overflows. Then step increments.
  - On the edge where step==W-1, go to REPORT and register out_golden=final acc and out_err=(prod_q != final acc).
  - MUL takes exactly W cycles.
- REPORT:
  - out_valid=1. out_prod, out_golden and out_err are stable and held while out_ready is low (backpressure may last indefinitely).
  - The output handshake fires when out_valid and out_ready are both high at a clk edge. On that edge:
    - if out_err=1, err_count increments;
    - out_valid drops, in_ready rises, state goes to IDLE.
- Latency: out_valid asserts exactly W cycles after the input handshake edge.
- Throughput: at most one transaction every W+2 cycles. There is no overlap; in_valid is ignored outside IDLE.
- Counter rules:
  - err_count saturates at 2^CNT_W-1 and never wraps.
  - err_sat sets on the edge where err_count reaches all-ones and stays set.
  - clr_count=1 at an edge forces err_count=0 and err_sat=0. This wins over a simultaneous increment, and the error being counted at that edge is lost.
  - clr_count has no effect on the FSM or data outputs.
- Boundary cases:
  - Operand 0 in either position gives golden 0.
  - Max operands 15*15 give golden 225.
  - in_prod bits are compared in full; any single-bit difference flags an error.
- out_err, out_prod and out_golden keep their last values after the output handshake until the next REPORT entry.

Decomposition:
- Package mult_chk_pkg:
  - state enum (IDLE, MUL, REPORT);
  - localparams PW=2*W and STEP_W=$clog2(W);
  - the default CNT_W value.
- One natural sub-module, shift_add_mult4:
  - contains the accumulator, step counter and done pulse;
  - inputs: start, a, b; outputs: busy, done, product;
  - the checker top holds the FSM, capture registers, compare and counter.

Test Plan:
- Reset release, then in_a=15, in_b=15, in_prod=225 → out_valid exactly 4 cycles after the accept edge, out_golden=225, out_err=0, err_count stays 0.
- in_a=9, in_b=6, in_prod=54^8'h01=55 → out_golden=54, out_err=1; err_count=1 after the output handshake.
- in_a=0, in_b=13, in_prod=0, with out_ready held low 10 cycles → outputs stable, in_ready stays 0, in_valid pulses ignored; a single result when out_ready rises.
- CNT_W=2, four erroneous transactions → err_count goes 1, 2, 3, 3; err_sat=1 after the third; clr_count together with a fifth error handshake → err_count=0, err_sat=0.
- rst_n pulled low mid-MUL after in_a=7, in_b=5 → all outputs 0 immediately; no out_valid follows; a new transaction 3*4=12 after release checks correctly.
- Exhaustive sweep of all 256 (A,B) pairs with in_prod from a correct model, back-to-back with out_ready=1 → zero errors, accept-to-accept period of 6 cycles.

Source files
------------

// File: rtl/mult_chk_pkg.sv
// Shared types and sizing for the 4-bit multiplier result checker.
// Defaults here seed the top-level parameters.
package mult_chk_pkg;

  localparam int W_DEF     = 4;
  localparam int PW        = 2 * W_DEF;
  localparam int STEP_W    = $clog2(W_DEF);
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mult4.sv
// Sequential shift-add multiplier: W cycles after start, done pulses with the full product.
// No backpressure; the caller holds a/b stable while busy.
module shift_add_mult4
  import mult_chk_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int PW_L = 2 * W;
  localparam int SW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(W - 1);

  logic            busy_q, busy_d;
  logic [SW-1:0]   step_q, step_d;
  logic [PW_L-1:0] acc_q, acc_d;
  logic [PW_L-1:0] term;

  always_comb begin
    term   = b[step_q] ? (PW_L'(a) << step_q) : '0;
    done   = busy_q && (step_q == LAST_STEP);
    busy_d = busy_q;
    step_d = step_q;
    acc_d  = acc_q;
    if (start) begin
      busy_d = 1'b1;
      step_d = '0;
      acc_d  = '0;
    end else if (busy_q) begin
      acc_d  = acc_q + term;
      step_d = step_q + SW'(1);
      if (done) busy_d = 1'b0;
    end
  end

  // The final partial product is folded in combinationally so done and product line up.
  assign product = acc_q + term;
  assign busy    = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      step_q <= '0;
      acc_q  <= '0;
    end else begin
      busy_q <= busy_d;
      step_q <= step_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/mult4u_result_checker.sv
// Checks a multiplier's product against a shift-add golden; result valid W cycles after accept.
// Result held in REPORT under out_ready backpressure; inputs refused until it is taken.
module mult4u_result_checker
  import mult_chk_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [2*W-1:0]   in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_prod,
  output logic [2*W-1:0]   out_golden,
  output logic             out_err,
  input  logic             clr_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_sat
);

  localparam int PW_L = 2 * W;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [PW_L-1:0]  prod_q, prod_d;
  logic [PW_L-1:0]  out_prod_q, out_prod_d;
  logic [PW_L-1:0]  out_golden_q, out_golden_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic             in_fire, out_fire;
  logic             mul_busy, mul_done;
  logic [PW_L-1:0]  mul_product;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  shift_add_mult4 #(.W(W)) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (in_fire && !mul_busy),
    .a       (a_q),
    .b       (b_q),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    prod_d       = prod_q;
    out_prod_d   = out_prod_q;
    out_golden_d = out_golden_q;
    out_err_d    = out_err_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          a_d     = in_a;
          b_d     = in_b;
          prod_d  = in_prod;
          state_d = MUL;
        end
      end
      MUL: begin
        if (mul_done) begin
          out_prod_d   = prod_q;
          out_golden_d = mul_product;
          out_err_d    = (prod_q != mul_product);
          state_d      = REPORT;
        end
      end
      REPORT: begin
        if (out_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == REPORT);

    // Counter saturates; a clear on the same edge drops the error being counted.
    cnt_d = cnt_q;
    if (out_fire && out_err_q && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    sat_d = sat_q | (cnt_d == '1);
    if (clr_count) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      prod_q       <= '0;
      out_prod_q   <= '0;
      out_golden_q <= '0;
      out_err_q    <= 1'b0;
      cnt_q        <= '0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      a_q          <= a_d;
      b_q          <= b_d;
      prod_q       <= prod_d;
      out_prod_q   <= out_prod_d;
      out_golden_q <= out_golden_d;
      out_err_q    <= out_err_d;
      cnt_q        <= cnt_d;
      sat_q        <= sat_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_prod   = out_prod_q;
  assign out_golden = out_golden_q;
  assign out_err    = out_err_q;
  assign err_count  = cnt_q;
  assign err_sat    = sat_q;

endmodule

// File: tb/tb_mult4u_result_checker.sv
// Directed bench for mult4u_result_checker; a second instance with a 2-bit counter
// shares all stimulus so saturation can be observed alongside the default build.
module tb_mult4u_result_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, clr_count;
  logic [3:0] in_a, in_b;
  logic [7:0] in_prod;

  logic        in_ready, out_valid, out_err, err_sat;
  logic [7:0]  out_prod, out_golden;
  logic [15:0] err_count;
  logic        in_ready2, out_valid2, out_err2, err_sat2;
  logic [7:0]  out_prod2, out_golden2;
  logic [1:0]  err_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult4u_result_checker dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_prod(in_prod), .out_valid(out_valid),
    .out_ready(out_ready), .out_prod(out_prod), .out_golden(out_golden),
    .out_err(out_err), .clr_count(clr_count), .err_count(err_count), .err_sat(err_sat)
  );

  mult4u_result_checker #(.W(4), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_prod(in_prod), .out_valid(out_valid2),
    .out_ready(out_ready), .out_prod(out_prod2), .out_golden(out_golden2),
    .out_err(out_err2), .clr_count(clr_count), .err_count(err_count2), .err_sat(err_sat2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full transaction; clr_count is raised on the output handshake edge when clr_at_fire.
  task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input logic [7:0] p,
                         input logic [7:0] exp_g, input logic exp_e, input int stall,
                         input logic clr_at_fire);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_prod = p;
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_drops", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 4);
    chk("out_golden", out_golden, exp_g);
    chk("out_err", out_err, exp_e);
    chk("out_prod", out_prod, p);
    chk("out_golden_c2", out_golden2, exp_g);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; in_a = ~a; in_b = 4'(i); in_prod = 8'(i);
      @(negedge clk);
      in_valid = 1'b0;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_golden", out_golden, exp_g);
      chk("stall_prod", out_prod, p);
      chk("stall_err", out_err, exp_e);
    end
    out_ready = 1'b1;
    clr_count = clr_at_fire;
    @(negedge clk);
    out_ready = 1'b0;
    clr_count = 1'b0;
    chk("out_valid_after_fire", out_valid, 0);
    chk("in_ready_after_fire", in_ready, 1);
    chk("golden_held_after_fire", out_golden, exp_g);
  endtask

  logic [3:0] ea [4];
  logic [3:0] eb [4];
  logic [7:0] ep [4];
  logic [7:0] eg [4];
  logic [1:0] exp_c2 [4];
  logic       exp_s2 [4];

  int idx, cyc, last_acc, n_res, seen;
  logic pend;
  logic [7:0] exp_g;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_count = 1'b0;
    in_a = '0; in_b = '0; in_prod = '0;
    ea = '{4'd2, 4'd15, 4'd8, 4'd1};
    eb = '{4'd3, 4'd1, 4'd8, 4'd1};
    ep = '{8'd7, 8'd14, 8'hC0, 8'd0};
    eg = '{8'd6, 8'd15, 8'd64, 8'd1};
    exp_c2 = '{2'd1, 2'd2, 2'd3, 2'd3};
    exp_s2 = '{1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_prod", out_prod, 0);
    chk("rst_out_golden", out_golden, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_err_sat", err_sat, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_release", in_ready, 1);

    // Max operands, correct product
    run_txn(4'd15, 4'd15, 8'd225, 8'd225, 1'b0, 0, 1'b0);
    chk("t1_err_count", err_count, 0);

    // Single-bit corrupted product
    run_txn(4'd9, 4'd6, 8'd55, 8'd54, 1'b1, 0, 1'b0);
    chk("t2_err_count", err_count, 1);
    chk("t2_err_count_c2", err_count2, 1);

    // Zero operand under 10 cycles of backpressure with ignored in_valid pulses
    run_txn(4'd0, 4'd13, 8'd0, 8'd0, 1'b0, 10, 1'b0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("t3_single_result", seen, 0);
    chk("t3_idle_in_ready", in_ready, 1);
    chk("t3_err_count", err_count, 1);

    // Saturation on the 2-bit counter
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    chk("clr_err_count", err_count, 0);
    chk("clr_err_count_c2", err_count2, 0);
    for (int k = 0; k < 4; k++) begin
      run_txn(ea[k], eb[k], ep[k], eg[k], 1'b1, 0, 1'b0);
      chk("sat_count_c2", err_count2, exp_c2[k]);
      chk("sat_flag_c2", err_sat2, exp_s2[k]);
      chk("sat_count_c16", err_count, k + 1);
      chk("sat_flag_c16", err_sat, 0);
    end
    run_txn(4'd5, 4'd5, 8'h09, 8'h19, 1'b1, 0, 1'b1);
    chk("clr_wins_count", err_count, 0);
    chk("clr_wins_count_c2", err_count2, 0);
    chk("clr_wins_sat_c2", err_sat2, 0);

    // Reset in the middle of MUL
    in_valid = 1'b1; in_a = 4'd7; in_b = 4'd5; in_prod = 8'd35;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_err", out_err, 0);
    chk("midrst_out_prod", out_prod, 0);
    chk("midrst_out_golden", out_golden, 0);
    chk("midrst_err_count", err_count, 0);
    chk("midrst_err_sat", err_sat, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_result", seen, 0);
    run_txn(4'd3, 4'd4, 8'd12, 8'd12, 1'b0, 0, 1'b0);
    chk("midrst_err_count_after", err_count, 0);

    // Exhaustive back-to-back sweep
    idx = 0; cyc = 0; last_acc = -1; n_res = 0;
    out_ready = 1'b1; in_valid = 1'b1; in_a = '0; in_b = '0; in_prod = '0;
    while (n_res < 256 && cyc < 4000) begin
      pend = 1'b0;
      if (out_valid) begin
        chk("sweep_golden", out_golden, exp_g);
        chk("sweep_err", out_err, 0);
        n_res++;
      end
      if (in_valid && in_ready) begin
        if (last_acc >= 0) chk("sweep_period", cyc - last_acc, 6);
        last_acc = cyc;
        exp_g = {4'b0, in_a} * {4'b0, in_b};
        pend = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (pend) begin
        idx++;
        if (idx < 256) begin
          in_a = idx[7:4];
          in_b = idx[3:0];
          in_prod = {4'b0, in_a} * {4'b0, in_b};
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    chk("sweep_results", n_res, 256);
    chk("sweep_err_count", err_count, 0);
    chk("sweep_err_sat", err_sat, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
